// File: rtl/alu_stage.sv
// alu_stage: add/sub/and in one cycle or 16-cycle shift-add multiply over the A/B register outputs
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   aout       A register contents (operand 1 / multiplicand)
//   bout       B register contents (operand 2 / multiplier)
//   alu_op     00 add, 01 sub, 10 mul, 11 and
//   alu_start  start request, accepted only in IDLE
//   alu_en     gates the result register onto alu_out (0 when low)
//   alu_out    gated result
//   alu_busy   high whenever the FSM is not IDLE
//   alu_done   one-cycle pulse after result/flags update
//   carry_flag registered carry / no-borrow / multiply overflow
//   zero_flag  registered result==0
module alu_stage #(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] aout,
   input  logic [WIDTH-1:0] bout,
   input  logic [1:0]       alu_op,
   input  logic             alu_start,
   input  logic             alu_en,
   output logic [WIDTH-1:0] alu_out,
   output logic             alu_busy,
   output logic             alu_done,
   output logic             carry_flag,
   output logic             zero_flag
);
   localparam int CW = $clog2(MUL_CYCLES);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q;
   logic               zero_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      count_q;

   logic [WIDTH:0]     add_w;
   logic [WIDTH:0]     sub_w;
   logic [WIDTH-1:0]   op_res;
   logic               op_c;
   logic [2*WIDTH-1:0] acc_d;

   always_comb begin
      add_w  = {1'b0, aout} + {1'b0, bout};
      sub_w  = {1'b0, aout} - {1'b0, bout};
      op_res = alu_op == 2'b00 ? add_w[WIDTH-1:0] :
               alu_op == 2'b01 ? sub_w[WIDTH-1:0] : aout & bout;
      // borrow out of the 17-bit subtract is the inverse of aout >= bout
      op_c   = alu_op == 2'b00 ? add_w[WIDTH] :
               alu_op == 2'b01 ? ~sub_w[WIDTH] : 1'b0;
      acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (alu_start) begin
               if (alu_op == 2'b10) begin
                  mcand_q  <= {{WIDTH{1'b0}}, aout};
                  mplier_q <= bout;
                  acc_q    <= '0;
                  count_q  <= '0;
                  state_q  <= MUL;
               end else begin
                  result_q <= op_res;
                  carry_q  <= op_c;
                  zero_q   <= op_res == '0;
                  state_q  <= DONE;
               end
            end
            MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               // commit straight from acc_d so the last partial product is included
               if (count_q == CW'(MUL_CYCLES - 1)) begin
                  result_q <= acc_d[WIDTH-1:0];
                  carry_q  <= |acc_d[2*WIDTH-1:WIDTH];
                  zero_q   <= acc_d[WIDTH-1:0] == '0;
                  state_q  <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_out    = alu_en ? result_q : '0;
   assign alu_busy   = state_q != IDLE;
   assign alu_done   = state_q == DONE;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: table-driven and scoreboard check of alu_stage
module tb_alu_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] aout = '0;
   logic [15:0] bout = '0;
   logic [1:0]  alu_op = '0;
   logic        alu_start = 1'b0;
   logic        alu_en = 1'b1;
   logic [15:0] alu_out;
   logic        alu_busy, alu_done, carry_flag, zero_flag;

   always #5 clk = ~clk;

   alu_stage #(.WIDTH(16), .MUL_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .aout(aout), .bout(bout), .alu_op(alu_op),
      .alu_start(alu_start), .alu_en(alu_en), .alu_out(alu_out),
      .alu_busy(alu_busy), .alu_done(alu_done),
      .carry_flag(carry_flag), .zero_flag(zero_flag)
   );

   typedef struct packed {logic [15:0] res; logic c; logic z;} exp_t;
   typedef struct {logic [1:0] op; logic [15:0] a; logic [15:0] b; logic [15:0] res; logic c; logic z;} vec_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [16:0] s;
      logic [31:0] p;
      s = {1'b0, a} + {1'b0, b};
      p = {16'h0, a} * {16'h0, b};
      case (op)
         2'd0:    begin e.res = s[15:0]; e.c = s[16]; end
         2'd1:    begin e.res = a - b; e.c = (a >= b); end
         2'd2:    begin e.res = p[15:0]; e.c = |p[31:16]; end
         default: begin e.res = a & b; e.c = 1'b0; end
      endcase
      e.z = (e.res == 16'h0);
      return e;
   endfunction

   task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input exp_t e);
      aout = a;
      bout = b;
      alu_op = op;
      alu_start = 1'b1;
      sb.push_back(e);
      tick();
      alu_start = 1'b0;
   endtask

   // lat: edges after the start edge before alu_done is seen; perturb/poke: cycle to
   // change operands / pulse start while busy (-1 = never); poke_done pulses start in DONE
   task automatic finish_op(input int lat, input int perturb, input int poke, input bit poke_done);
      int   n;
      exp_t e;
      n = 0;
      e = '0;
      while (!alu_done && n < 40) begin
         chk("busy_run", alu_busy, 1);
         if (n == perturb) begin
            aout = 16'd9;
            bout = 16'd7;
         end
         alu_start = (n == poke);
         tick();
         alu_start = 1'b0;
         n++;
      end
      chk("latency", n, lat);
      chk("sb_level", sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      chk("done", alu_done, 1);
      chk("result", alu_out, e.res);
      chk("carry", carry_flag, e.c);
      chk("zero", zero_flag, e.z);
      alu_en = 1'b0;
      #1;
      chk("out_gated", alu_out, 0);
      alu_en = 1'b1;
      if (poke_done) begin
         aout = 16'd1;
         bout = 16'd1;
         alu_op = 2'd0;
         alu_start = 1'b1;
      end
      tick();
      alu_start = 1'b0;
      chk("done_pulse", alu_done, 0);
      chk("busy_idle", alu_busy, 0);
      chk("result_hold", alu_out, e.res);
      chk("carry_hold", carry_flag, e.c);
      chk("zero_hold", zero_flag, e.z);
   endtask

   initial begin
      vec_t vecs[10];
      exp_t e;
      vecs[0] = '{2'd0, 16'd400,   16'd100,   16'd500,   1'b0, 1'b0};
      vecs[1] = '{2'd1, 16'd100,   16'd400,   16'hFED4,  1'b0, 1'b0};
      vecs[2] = '{2'd1, 16'd400,   16'd400,   16'd0,     1'b1, 1'b1};
      vecs[3] = '{2'd2, 16'd400,   16'd3,     16'd1200,  1'b0, 1'b0};
      vecs[4] = '{2'd2, 16'h0100,  16'h0100,  16'd0,     1'b1, 1'b1};
      vecs[5] = '{2'd2, 16'hFFFF,  16'd1,     16'hFFFF,  1'b0, 1'b0};
      vecs[6] = '{2'd0, 16'hFFFF,  16'd1,     16'd0,     1'b1, 1'b1};
      vecs[7] = '{2'd3, 16'hF0F0,  16'h3C3C,  16'h3030,  1'b0, 1'b0};
      vecs[8] = '{2'd1, 16'd5,     16'd3,     16'd2,     1'b1, 1'b0};
      vecs[9] = '{2'd0, 16'd0,     16'd0,     16'd0,     1'b0, 1'b1};

      #12 rst = 1'b1;
      #6;
      chk("rst_busy", alu_busy, 0);
      chk("rst_done", alu_done, 0);
      chk("rst_out", alu_out, 0);
      chk("rst_carry", carry_flag, 0);
      chk("rst_zero", zero_flag, 0);
      #1 rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         e = '{vecs[i].res, vecs[i].c, vecs[i].z};
         start_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
         finish_op(vecs[i].op == 2'd2 ? 16 : 0, -1, -1, 1'b0);
      end

      // operands change mid-multiply; snapshot must win
      start_op(2'd2, 16'd400, 16'd3, '{16'd1200, 1'b0, 1'b0});
      finish_op(16, 5, -1, 1'b0);

      // start pulsed in MUL and in DONE is ignored; add right after DONE is accepted
      start_op(2'd2, 16'd400, 16'd3, '{16'd1200, 1'b0, 1'b0});
      finish_op(16, -1, 3, 1'b1);
      start_op(2'd0, 16'd7, 16'd8, '{16'd15, 1'b0, 1'b0});
      finish_op(0, -1, -1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         logic [1:0]  op;
         logic [15:0] a, b;
         op = 2'($urandom_range(0, 3));
         a = 16'($urandom);
         b = 16'($urandom);
         start_op(op, a, b, model(op, a, b));
         finish_op(op == 2'd2 ? 16 : 0, -1, -1, 1'b0);
      end

      // async reset in multiply cycle 8, after flags were left at 1
      start_op(2'd1, 16'd400, 16'd400, '{16'd0, 1'b1, 1'b1});
      finish_op(0, -1, -1, 1'b0);
      start_op(2'd2, 16'd400, 16'd3, '{16'd1200, 1'b0, 1'b0});
      repeat (8) tick();
      chk("pre_rst_busy", alu_busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", alu_busy, 0);
      chk("arst_done", alu_done, 0);
      chk("arst_carry", carry_flag, 0);
      chk("arst_zero", zero_flag, 0);
      chk("arst_out", alu_out, 0);
      sb.delete();
      #3 rst = 1'b0;
      tick();
      chk("post_rst_out", alu_out, 0);
      chk("post_rst_busy", alu_busy, 0);
      start_op(2'd0, 16'd7, 16'd8, '{16'd15, 1'b0, 1'b0});
      finish_op(0, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
